// File: rtl/wb_grf_pkg.sv
// Shared definitions for the MIPS write-back stage and register file:
// sizes, opcode/funct encodings, decode records and the load-extension helper.
package wb_grf_pkg;

   localparam int NREG = 32;
   localparam int DW   = 32;
   localparam int AW   = 5;

   localparam logic [AW-1:0] REG_ZERO = 5'd0;
   localparam logic [AW-1:0] REG_LINK = 5'd31;

   // Primary opcodes
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29;
   localparam logic [5:0] OP_SW      = 6'h2B;

   // SPECIAL funct codes
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT, DST_LINK} dst_t;
   typedef enum logic [1:0] {SRC_ALU, SRC_PC8, SRC_MEM} src_t;
   typedef enum logic [2:0] {LD_W, LD_B, LD_BU, LD_H, LD_HU} ld_t;

   typedef struct packed {
      dst_t dst;
      src_t src;
      ld_t  ld;
   } dec_t;

   localparam dec_t DEC_NOP = '{dst: DST_NONE, src: SRC_ALU, ld: LD_W};

   function automatic dec_t decode_instr(logic [5:0] op, logic [5:0] funct);
      dec_t d;
      d = DEC_NOP;
      unique case (op)
         OP_SPECIAL: begin
            unique case (funct)
               FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_NOR, FN_XOR, FN_SLT, FN_SLTU,
               FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV:
                  d = '{dst: DST_RD, src: SRC_ALU, ld: LD_W};
               FN_JALR:
                  d = '{dst: DST_RD, src: SRC_PC8, ld: LD_W};
               default:
                  d = DEC_NOP;
            endcase
         end
         OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI, OP_SLTIU:
            d = '{dst: DST_RT, src: SRC_ALU, ld: LD_W};
         OP_LW:  d = '{dst: DST_RT, src: SRC_MEM, ld: LD_W};
         OP_LB:  d = '{dst: DST_RT, src: SRC_MEM, ld: LD_B};
         OP_LBU: d = '{dst: DST_RT, src: SRC_MEM, ld: LD_BU};
         OP_LH:  d = '{dst: DST_RT, src: SRC_MEM, ld: LD_H};
         OP_LHU: d = '{dst: DST_RT, src: SRC_MEM, ld: LD_HU};
         OP_JAL: d = '{dst: DST_LINK, src: SRC_PC8, ld: LD_W};
         default: d = DEC_NOP;
      endcase
      return d;
   endfunction

   // Little-endian sub-word select; lh/lhu ignore addr[0], lw ignores both bits.
   function automatic logic [DW-1:0] load_extend(ld_t kind, logic [1:0] addr,
                                                 logic [DW-1:0] word);
      logic [7:0]    b;
      logic [15:0]   h;
      logic [DW-1:0] r;
      unique case (addr)
         2'd0: b = word[7:0];
         2'd1: b = word[15:8];
         2'd2: b = word[23:16];
         default: b = word[31:24];
      endcase
      h = addr[1] ? word[31:16] : word[15:0];
      unique case (kind)
         LD_B:    r = {{24{b[7]}}, b};
         LD_BU:   r = {24'h0, b};
         LD_H:    r = {{16{h[15]}}, h};
         LD_HU:   r = {16'h0, h};
         default: r = word;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/wb_decode.sv
// Combinational W-stage decode: destination register, write data (with load
// extension) and write enable from the W-stage pipeline register.
module wb_decode
   import wb_grf_pkg::*;
(
   input  logic [31:0]   Instr_W,
   input  logic [DW-1:0] ALUOut_W,
   input  logic [DW-1:0] RD_W,
   input  logic [DW-1:0] PC8_W,
   output logic [AW-1:0] WA_W,
   output logic [DW-1:0] WD_W,
   output logic          WE_W
);

   logic [5:0]    op;
   logic [5:0]    funct;
   logic [AW-1:0] rt;
   logic [AW-1:0] rd;
   dec_t          dec;
   logic [AW-1:0] wa_raw;
   logic [DW-1:0] wd_raw;
   logic          unused_fields;

   assign op    = Instr_W[31:26];
   assign rt    = Instr_W[20:16];
   assign rd    = Instr_W[15:11];
   assign funct = Instr_W[5:0];
   assign unused_fields = ^{Instr_W[25:21], Instr_W[10:6]};

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      dec    = decode_instr(op, funct);
      wa_raw = REG_ZERO;
      wd_raw = '0;
      unique case (dec.dst)
         DST_RD:   wa_raw = rd;
         DST_RT:   wa_raw = rt;
         DST_LINK: wa_raw = REG_LINK;
         default:  wa_raw = REG_ZERO;
      endcase
      unique case (dec.src)
         SRC_PC8: wd_raw = PC8_W;
         SRC_MEM: wd_raw = load_extend(dec.ld, ALUOut_W[1:0], RD_W);
         default: wd_raw = ALUOut_W;
      endcase
   end

   // $0 is never a real destination, so nothing downstream ever sees it as one.
   assign WE_W = (wa_raw != REG_ZERO);
   assign WA_W = wa_raw;
   assign WD_W = WE_W ? wd_raw : '0;

endmodule

// File: rtl/wb_grf.sv
// W stage plus 32x32 register file with same-cycle write-to-read bypass.
// Optional GRF_TRACE_EN prints a judge-format line for every committed write.
module wb_grf
   import wb_grf_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   Instr_W,
   input  logic [31:0]   PC_W,
   input  logic [DW-1:0] PC8_W,
   input  logic [DW-1:0] ALUOut_W,
   input  logic [DW-1:0] RD_W,
   input  logic [AW-1:0] A1,
   input  logic [AW-1:0] A2,
   output logic [DW-1:0] RD1,
   output logic [DW-1:0] RD2,
   output logic [AW-1:0] WA_W,
   output logic [DW-1:0] WD_W,
   output logic          WE_W
);

   logic [DW-1:0] grf [NREG];

   wb_decode u_decode (
      .Instr_W  (Instr_W),
      .ALUOut_W (ALUOut_W),
      .RD_W     (RD_W),
      .PC8_W    (PC8_W),
      .WA_W     (WA_W),
      .WD_W     (WD_W),
      .WE_W     (WE_W)
   );

   // NOTE: the array is reset entry by entry because software relies on all-zero registers after reset; this rules out a RAM macro.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) grf[i] <= '0;
      end else if (WE_W) begin
         grf[WA_W] <= WD_W;
      end
   end

`ifdef GRF_TRACE_EN
   always_ff @(posedge clk) begin
      if (!reset && WE_W) $display("%d@%h: $%d <= %h", $time, PC_W, WA_W, WD_W);
   end
`else
   logic unused_pc;
   assign unused_pc = ^PC_W;
`endif

   // D reads the value W is writing this cycle, so no extra forwarding is needed for W->D.
   assign RD1 = (A1 == REG_ZERO)             ? '0   :
                (WE_W && (A1 == WA_W))       ? WD_W : grf[A1];
   assign RD2 = (A2 == REG_ZERO)             ? '0   :
                (WE_W && (A2 == WA_W))       ? WD_W : grf[A2];

endmodule
